// File: rtl/pe_collect_pkg.sv
// Shared types for the PE output collector: lane/vector types and serializer states.
package pe_collect_pkg;

   localparam int unsigned N_PE_DEF        = 8;
   localparam int unsigned WID_PE_BITS_DEF = 16;

   typedef logic [WID_PE_BITS_DEF-1:0]          lane_t;
   typedef logic [N_PE_DEF*WID_PE_BITS_DEF-1:0] vec_t;

   typedef enum logic {
      IDLE,
      WRITE
   } coll_state_t;

   // A lane request of zero or beyond the array width means "all lanes".
   function automatic int unsigned eff_lanes(input int unsigned req, input int unsigned n_pe);
      return ((req == 0) || (req > n_pe)) ? n_pe : req;
   endfunction

endpackage

// File: rtl/pe_vec_fifo.sv
// Whole-vector FIFO; a push coinciding with flush lands in the freshly emptied queue.
module pe_vec_fifo
   import pe_collect_pkg::*;
#(
   parameter int unsigned WIDTH = N_PE_DEF * WID_PE_BITS_DEF,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_idx;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push & (flush | ~full);
   assign do_pop  = pop & ~empty & ~flush;
   assign wr_idx  = flush ? '0 : wr_ptr;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= do_push ? ptr_next('0) : '0;
         count_q <= do_push ? CNT_W'(1) : '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= din;
   end

endmodule

// File: rtl/pe_output_collector.sv
// Captures PE result vectors into a FIFO and serializes them lane by lane
// into a valid/ready word-write stream with a linearly incrementing address.
module pe_output_collector
   import pe_collect_pkg::*;
#(
   parameter int unsigned N_PE        = 8,
   parameter int unsigned WID_PE_BITS = 16,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [$clog2(N_PE+1)-1:0]   num_lanes,
   input  logic                        capture,
   input  logic [N_PE*WID_PE_BITS-1:0] pe_bus,
   output logic                        full,
   output logic                        wr_en,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [WID_PE_BITS-1:0]      wr_data,
   input  logic                        wr_ready,
   output logic                        busy,
   output logic                        overflow,
   output logic [CNT_W-1:0]            words_written
);

   localparam int unsigned LN_W = $clog2(N_PE + 1);
   localparam int unsigned VW   = N_PE * WID_PE_BITS;

   coll_state_t                  state_q, state_d;
   logic [VW-1:0]                fifo_dout, shadow_q;
   logic                         fifo_empty, pop, accept, last;
   logic [$clog2(DEPTH+1)-1:0]   fifo_count;
   logic [LN_W-1:0]              lane_idx_q, lanes_q;
   logic [ADDR_W-1:0]            addr_q;
   logic [CNT_W-1:0]             ww_q;
   logic                         ovf_q;

   pe_vec_fifo #(
      .WIDTH (VW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (start),
      .push  (capture),
      .din   (pe_bus),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign accept        = wr_en & wr_ready;
   assign last          = (lane_idx_q == lanes_q - LN_W'(1));
   assign wr_addr       = addr_q;
   assign overflow      = ovf_q;
   assign words_written = ww_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Refilling the shadow on the last-lane acceptance keeps vectors gap-free.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (accept && last) begin
               if (!fifo_empty) pop = 1'b1;
               else             state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         pop     = 1'b0;
         state_d = IDLE;
      end
   end

   always_comb begin
      wr_en   = (state_q == WRITE);
      busy    = (state_q != IDLE) || (fifo_count != '0);
      wr_data = '0;
      for (int unsigned i = 0; i < N_PE; i++) begin
         if (lane_idx_q == LN_W'(i)) wr_data = shadow_q[i*WID_PE_BITS +: WID_PE_BITS];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q   <= '0;
         lane_idx_q <= '0;
         lanes_q    <= LN_W'(N_PE);
         addr_q     <= '0;
         ww_q       <= '0;
         ovf_q      <= 1'b0;
      end else if (start) begin
         lane_idx_q <= '0;
         lanes_q    <= LN_W'(eff_lanes(32'(num_lanes), N_PE));
         addr_q     <= base_addr;
         ww_q       <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (capture && full) ovf_q <= 1'b1;
         if (accept) begin
            addr_q     <= addr_q + ADDR_W'(1);
            ww_q       <= ww_q + CNT_W'(1);
            lane_idx_q <= last ? '0 : lane_idx_q + LN_W'(1);
         end
         if (pop) begin
            shadow_q   <= fifo_dout;
            lane_idx_q <= '0;
         end
      end
   end

endmodule
